// File: rtl/det_matrix_loader_if.sv
// Bus bundle between the determinant loader, its entry source, the engine and the result consumer.
// The slave modport is the loader's view; the master modport is the environment's view.
interface det_matrix_loader_if #(
  parameter int N = 8,
  parameter int W = 32
);
  logic               in_valid;
  logic [W-1:0]       in_data;
  logic               in_ready;
  logic               flush;
  logic [N*N*W-1:0]   mat_flat;
  logic               eng_start;
  logic               eng_done;
  logic [W-1:0]       eng_det;
  logic               eng_ack;
  logic               det_valid;
  logic [W-1:0]       det_out;
  logic               det_ready;
  logic               q_Fill;
  logic               q_Kick;
  logic               q_Wait;
  logic               q_Result;

  modport slave (
    input  in_valid, in_data, flush, eng_done, eng_det, det_ready,
    output in_ready, mat_flat, eng_start, eng_ack, det_valid, det_out,
    output q_Fill, q_Kick, q_Wait, q_Result
  );

  modport master (
    output in_valid, in_data, flush, eng_done, eng_det, det_ready,
    input  in_ready, mat_flat, eng_start, eng_ack, det_valid, det_out,
    input  q_Fill, q_Kick, q_Wait, q_Result
  );
endinterface

// File: rtl/det_matrix_loader.sv
// Buffers an N x N signed matrix streamed row-major, kicks the determinant engine,
// captures its result and returns it on a valid/ready port before acknowledging the engine.
module det_matrix_loader #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  det_matrix_loader_if.slave   bus
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN) + 1;

  typedef enum logic [3:0] {
    S_FILL   = 4'b0001,
    S_KICK   = 4'b0010,
    S_WAIT   = 4'b0100,
    S_RESULT = 4'b1000
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [NN*W-1:0] r_mat;
  logic            r_eng_start;
  logic            r_eng_ack;
  logic            r_det_valid;
  logic [W-1:0]    r_det_out;
  logic            w_accept;
  logic            w_last;
  logic            w_flush;
  logic            w_capture;
  logic            w_handshake;

  // Next state and per-cycle events; flush beats a same-cycle entry beat.
  always_comb begin
    w_next      = S_FILL;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_flush     = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_FILL: begin
        if (bus.flush) begin
          w_flush = 1'b1;
          w_next  = S_FILL;
        end else if (bus.in_valid) begin
          w_accept = 1'b1;
          if (r_cnt == CW'(NN - 1)) begin
            w_last = 1'b1;
            w_next = S_KICK;
          end else begin
            w_next = S_FILL;
          end
        end else begin
          w_next = S_FILL;
        end
      end
      S_KICK: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done) begin
          w_capture = 1'b1;
          w_next    = S_RESULT;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESULT: begin
        if (r_det_valid && bus.det_ready) begin
          w_handshake = 1'b1;
          w_next      = S_FILL;
        end else begin
          w_next = S_RESULT;
        end
      end
      default: w_next = S_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Beat counter: cleared by flush or after the final beat of a matrix.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_flush || w_last) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Matrix buffer: entries are only ever overwritten, never cleared outside reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mat <= {(NN*W){1'b0}};
    end else if (w_accept) begin
      r_mat[int'(r_cnt) * W +: W] <= bus.in_data;
    end else begin
      r_mat <= r_mat;
    end
  end

  // Engine pulses and result register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_eng_start <= 1'b0;
      r_eng_ack   <= 1'b0;
      r_det_valid <= 1'b0;
      r_det_out   <= {W{1'b0}};
    end else begin
      r_eng_start <= w_last;
      r_eng_ack   <= w_handshake;
      if (w_capture) begin
        r_det_valid <= 1'b1;
        r_det_out   <= bus.eng_det;
      end else if (w_handshake) begin
        r_det_valid <= 1'b0;
        r_det_out   <= r_det_out;
      end else begin
        r_det_valid <= r_det_valid;
        r_det_out   <= r_det_out;
      end
    end
  end

  assign bus.mat_flat  = r_mat;
  assign bus.eng_start = r_eng_start;
  assign bus.eng_ack   = r_eng_ack;
  assign bus.det_valid = r_det_valid;
  assign bus.det_out   = r_det_out;
  assign bus.q_Fill    = (r_state == S_FILL);
  assign bus.q_Kick    = (r_state == S_KICK);
  assign bus.q_Wait    = (r_state == S_WAIT);
  assign bus.q_Result  = (r_state == S_RESULT);
  assign bus.in_ready  = (r_state == S_FILL);
endmodule
